fetch_align: RTL

- Instruction fetch/alignment stage sitting directly upstream of the compressed-instruction decoder.
- Requests word-aligned 32-bit words from instruction memory and buffers them as halfwords.
- Presents one instruction per handshake to the decoder: 16-bit compressed instructions in the low half, 32-bit instructions reassembled across word boundaries, each with its PC.
- Handles redirects (branch/jump) to any halfword-aligned target.

---
 rtl/fetch_align.sv | 75 +++++++
 1 files changed

// File: rtl/fetch_align.sv
// fetch_align: halfword-buffered instruction fetch/align stage feeding the decoder.
// Define FETCH_RVC_EN to enable 16-bit compressed instruction support.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_redirect,
  input  logic [31:0] I_redirectpc,
  output logic        O_fetchreq,
  output logic [31:0] O_fetchaddr,
  input  logic        I_fetchvalid,
  input  logic [31:0] I_fetchdata,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [31:0] O_data,
  output logic [31:0] O_pc
);
`ifdef FETCH_RVC_EN
  localparam logic RVC = 1'b1;
`else
  localparam logic RVC = 1'b0;
`endif
  localparam logic [31:0] PC_MASK = RVC ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
  logic [15:0] hw_q [3];
  logic [15:0] hw_d [3];
  logic [15:0] sh [3];
  logic [1:0]  cnt_q, cnt_d, rem, ncons;
  logic [31:0] pc_q, pc_d, faddr_q, faddr_d;
  logic        skip_q, skip_d, comp, consume, done;
  always_comb begin
    comp = RVC & (hw_q[0][1:0] != 2'b11);
    ncons = comp ? 2'd1 : 2'd2;
    O_valid = ((cnt_q != 2'd0) & comp) | (cnt_q >= 2'd2);
    consume = O_valid & I_ready;
    rem = cnt_q - (consume ? ncons : 2'd0);
    O_fetchreq = ~I_rst & ~I_redirect & (rem <= 2'd1);
    done = O_fetchreq & I_fetchvalid;
    O_fetchaddr = faddr_q;
    O_pc = pc_q;
    O_data = (cnt_q == 2'd0) ? 32'h0 : comp ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
    sh[0] = !consume ? hw_q[0] : comp ? hw_q[1] : hw_q[2];
    sh[1] = !consume ? hw_q[1] : hw_q[2];
    sh[2] = hw_q[2];
    // A completed word lands right after whatever survives this cycle's consume.
    for (int i = 0; i < 3; i++)
      hw_d[i] = (done && i == int'(rem)) ? (skip_q ? I_fetchdata[31:16] : I_fetchdata[15:0]) :
                (done && !skip_q && i == int'(rem) + 1) ? I_fetchdata[31:16] : sh[i];
    cnt_d = done ? rem + (skip_q ? 2'd1 : 2'd2) : rem;
    pc_d = consume ? pc_q + {29'd0, ncons, 1'b0} : pc_q;
    faddr_d = done ? faddr_q + 32'd4 : faddr_q;
    skip_d = done ? 1'b0 : skip_q;
    if (I_redirect) begin
      cnt_d = 2'd0;
      pc_d = I_redirectpc & PC_MASK;
      faddr_d = {I_redirectpc[31:2], 2'b00};
      skip_d = RVC & I_redirectpc[1];
    end
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int i = 0; i < 3; i++) hw_q[i] <= 16'h0;
      cnt_q <= 2'd0;
      pc_q <= RESET_PC & PC_MASK;
      faddr_q <= {RESET_PC[31:2], 2'b00};
      skip_q <= RVC & RESET_PC[1];
    end else begin
      for (int i = 0; i < 3; i++) hw_q[i] <= hw_d[i];
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      faddr_q <= faddr_d;
      skip_q <= skip_d;
    end
  end
endmodule
